// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the in-order WB stage (source 0)
// and the long-latency unit (source 1), with a starvation guard for source 1.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [4:0]       s0_reg,
  input  logic [31:0]      s0_data,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [4:0]       s1_reg,
  input  logic [31:0]      s1_data,
  output logic             RegWrite,
  output logic [4:0]       writeReg,
  output logic [31:0]      writeData,
  output logic             wb_src,
  output logic             force_s1,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic             reg_write_q, reg_write_d;
  logic [4:0]       write_reg_q, write_reg_d;
  logic [31:0]      write_data_q, write_data_d;
  logic             wb_src_q, wb_src_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  logic s0_hs, s1_hs;

  // Handshake: a transfer happens on a cycle where valid & ready are both high. Ready never
  // looks at the requester's own valid, and the two readys never allow two transfers at once.
  always_comb begin
    force_s1 = (wait_cnt_q == MaxWait);
    s0_ready = rst_n & ~(force_s1 & s1_valid);
    s1_ready = rst_n & (~s0_valid | force_s1);
    s0_hs    = s0_valid & s0_ready;
    s1_hs    = s1_valid & s1_ready;
  end

  // Writes to r0 are drained from the source but never reach the register file.
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    wb_src_d     = wb_src_q;
    if (s0_hs && (s0_reg != 5'd0)) begin
      reg_write_d  = 1'b1;
      write_reg_d  = s0_reg;
      write_data_d = s0_data;
      wb_src_d     = 1'b0;
    end else if (s1_hs && (s1_reg != 5'd0)) begin
      reg_write_d  = 1'b1;
      write_reg_d  = s1_reg;
      write_data_d = s1_data;
      wb_src_d     = 1'b1;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!s1_valid || s1_hs) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != MaxWait) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (s0_valid && s1_valid && (conflict_cnt_q != {CNT_W{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write_q    <= 1'b0;
      write_reg_q    <= 5'd0;
      write_data_q   <= 32'd0;
      wb_src_q       <= 1'b0;
      wait_cnt_q     <= 4'd0;
      conflict_cnt_q <= '0;
    end else begin
      reg_write_q    <= reg_write_d;
      write_reg_q    <= write_reg_d;
      write_data_q   <= write_data_d;
      wb_src_q       <= wb_src_d;
      wait_cnt_q     <= wait_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign RegWrite     = reg_write_q;
  assign writeReg     = write_reg_q;
  assign writeData    = write_data_q;
  assign wb_src       = wb_src_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources.
  - Source 0: the in-order pipeline WB stage.
  - Source 1: the long-latency unit (mul/div, cache-miss load return).
- Each source uses a valid/ready handshake. The block registers the winning write and drives RegWrite/writeReg/writeData into the register file one cycle later.
- Source 0 has fixed priority, with a starvation guard that forces a grant to source 1 after MAX_WAIT blocked cycles.

Parameters:
- MAX_WAIT, 4, consecutive blocked cycles of source 1 before it is forced through (legal 1..15).
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- s0_valid  input  1  source 0 has a write
- s0_ready  output  1  source 0 write accepted this cycle when valid&ready
- s0_reg  input  5  source 0 destination register
- s0_data  input  32  source 0 write data
- s1_valid  input  1  source 1 has a write
- s1_ready  output  1  source 1 accepted when valid&ready
- s1_reg  input  5  source 1 destination register
- s1_data  input  32  source 1 write data
- RegWrite  output  1  register-file write enable (registered)
- writeReg  output  5  register-file write address (registered)
- writeData  output  32  register-file write data (registered)
- wb_src  output  1  source of the current RegWrite (0/1)
- force_s1  output  1  starvation override active this cycle
- conflict_cnt  output  CNT_W  saturating count of cycles with s0_valid&s1_valid

Behaviour:
- Reset (rst_n=0 at posedge):
  - RegWrite=0, writeReg=0, writeData=0, wb_src=0.
  - wait_cnt=0, force_s1=0, conflict_cnt=0.
  - Any request present during reset is not accepted: s0_ready=s1_ready=0 while rst_n=0.
- Grant (combinational, never depends on the requester's own valid):
  - force_s1 = (wait_cnt == MAX_WAIT).
  - s0_ready = rst_n & ~(force_s1 & s1_valid).
  - s1_ready = rst_n & (~s0_valid | force_s1).
  - At most one handshake per cycle.
- Output register:
  - On a handshake from source k, the next cycle has RegWrite=1, writeReg=sk_reg, writeData=sk_data, wb_src=k.
  - With no handshake, RegWrite=0 next cycle. writeReg, writeData and wb_src hold their previous values.
  - Latency is exactly 1 cycle. Throughput is 1 write per cycle.
- Register 0:
  - A request with sk_reg=0 is still handshaken, so the source is drained.
  - RegWrite stays 0 for it. writeReg/writeData/wb_src are not updated.
- Starvation counter wait_cnt (width 4):
  - Increments when s1_valid & ~s1_ready.
  - Clears to 0 on an s1 handshake or when s1_valid=0.
  - Saturates at MAX_WAIT.
  - With s0 streaming continuously, s1 therefore waits exactly MAX_WAIT cycles and is granted on cycle MAX_WAIT+1. During that cycle s0 is stalled (s0_ready=0).
- conflict_cnt: increments when s0_valid & s1_valid, saturating at all-ones.
- Same destination from both sources in one cycle: only the granted one is written. The other is written on a later cycle. Ordering of writes to the same register across sources is the issuing logic's responsibility.
- Sources must hold sk_reg/sk_data stable while valid and not ready. The block does not check this.
- Reset mid-operation: a pending (not yet accepted) request is dropped from the arbiter's view. A registered write in flight is cancelled, so RegWrite=0 the cycle after reset is sampled.

Test Plan:
- Reset with s0_valid=1, s0_reg=5 -> s0_ready=0, RegWrite=0, conflict_cnt=0. After release, s0 is accepted and the next cycle shows RegWrite=1, writeReg=5, wb_src=0.
- Only s1_valid=1, s1_reg=9, s1_data=0xDEADBEEF -> s1_ready=1 the same cycle. The next cycle shows RegWrite=1, writeReg=9, writeData=0xDEADBEEF, wb_src=1.
- MAX_WAIT=4; s0 streams regs 1..8 every cycle and s1_valid=1 (reg 20) from cycle 0:
  - s1 is blocked on cycles 0-3.
  - Cycle 4: force_s1=1, s1_ready=1, s0_ready=0.
  - Cycle 5: writeReg=20, wb_src=1, and s0's reg 5 is accepted.
  - conflict_cnt=5 after cycle 4.
- s0_reg=0 valid with data 0x1234 -> s0_ready=1, RegWrite=0 next cycle, writeReg/writeData unchanged.
- Both sources valid for 1 cycle targeting reg 7 (s0 data 0xA, s1 data 0xB) -> the cycle after shows writeReg=7, writeData=0xA. s1 is written the following cycle with writeData=0xB.
- s1 blocked 3 cycles, s1_valid then drops 1 cycle, then reasserts -> wait_cnt restarts from 0, so force_s1 is first asserted 4 cycles after the reassertion.
